// File: rtl/uart_tx_fifo.sv
// Buffered UART transmitter: a FIFO feeds a frame FSM that serialises each byte
// LSB-first with start bit, optional parity and one or two stop bits.
module uart_tx_fifo #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115_200,
  parameter int DATA_BITS  = 8,
  parameter int PARITY_EN  = 0,
  parameter int PARITY_ODD = 0,
  parameter int STOP_BITS  = 1,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                          SYS_CLK,
  input  logic                          SYS_RST,
  input  logic [DATA_BITS-1:0]          i_DATA,
  input  logic                          i_WR,
  output logic                          o_FULL,
  output logic                          o_EMPTY,
  output logic [$clog2(FIFO_DEPTH):0]   o_COUNT,
  output logic                          o_OVERFLOW,
  output logic                          o_BUSY,
  output logic                          o_TX
);
  localparam int CPB = CLK_FREQ / BAUD;
  localparam int CW  = (CPB > 1) ? $clog2(CPB) : 1;
  localparam int AW  = $clog2(FIFO_DEPTH);

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
  state_t state, state_n;

  logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
  logic [AW-1:0]        wr_ptr, rd_ptr;
  logic [AW:0]          count;
  logic [CW-1:0]        baud_cnt;
  logic [3:0]           bit_cnt;
  logic [DATA_BITS-1:0] shift_q, shift_n;
  logic                 par_q, tx_q, tx_n, ovf_q;
  logic                 pop, wr_ok, bit_tick, full, empty;

  assign full     = (count == (AW+1)'(FIFO_DEPTH));
  assign empty    = (count == '0);
  assign wr_ok    = i_WR && !full;
  assign bit_tick = (baud_cnt == CW'(CPB - 1));

  // Full is judged on the registered count, so a same-edge pop never rescues a write.
  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      ovf_q  <= 1'b0;
    end else begin
      if (wr_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)   rd_ptr <= rd_ptr + 1'b1;
      if (i_WR && full) ovf_q <= 1'b1;
      case ({wr_ok, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge SYS_CLK) begin
    if (wr_ok) mem[wr_ptr] <= i_DATA;
  end

  always_comb begin
    state_n = state;
    pop     = 1'b0;
    shift_n = shift_q;
    case (state)
      IDLE:   if (!empty) begin pop = 1'b1; state_n = START; end
      START:  if (bit_tick) state_n = DATA;
      DATA:   if (bit_tick) begin
                shift_n = shift_q >> 1;
                if (bit_cnt == 4'(DATA_BITS - 1))
                  state_n = (PARITY_EN != 0) ? PARITY : STOP;
              end
      PARITY: if (bit_tick) state_n = STOP;
      STOP:   if (bit_tick && bit_cnt == 4'(STOP_BITS - 1)) begin
                if (!empty) begin pop = 1'b1; state_n = START; end
                else state_n = IDLE;
              end
      default: state_n = IDLE;
    endcase
    if (pop) shift_n = mem[rd_ptr];
    // Line level follows the state being entered so o_TX stays a plain register.
    case (state_n)
      START:   tx_n = 1'b0;
      DATA:    tx_n = shift_n[0];
      PARITY:  tx_n = par_q;
      default: tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge SYS_CLK or posedge SYS_RST) begin
    if (SYS_RST) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_cnt  <= '0;
      shift_q  <= '0;
      par_q    <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state   <= state_n;
      shift_q <= shift_n;
      tx_q    <= tx_n;
      if (pop) par_q <= (PARITY_ODD != 0) ? ~^mem[rd_ptr] : ^mem[rd_ptr];
      if (state_n != state) begin
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else if (bit_tick) begin
        baud_cnt <= '0;
        bit_cnt  <= bit_cnt + 1'b1;
      end else if (state != IDLE) begin
        baud_cnt <= baud_cnt + 1'b1;
      end
    end
  end

  assign o_TX       = tx_q;
  assign o_BUSY     = (state != IDLE);
  assign o_FULL     = full;
  assign o_EMPTY    = empty;
  assign o_COUNT    = count;
  assign o_OVERFLOW = ovf_q;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// Directed bench: four instances cover default framing, even/odd parity and two stop bits.
module tb_uart_tx_fifo;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] wr  = '0;
  logic [7:0] din [4];
  logic [3:0] tx, busy, full, empty, ovf;
  logic [4:0] cnt [4];
  int checks = 0;
  int failures = 0;
  logic samp [1700];

  always #5 clk = ~clk;

  uart_tx_fifo #(.BAUD(10_000_000)) u_a (
    .SYS_CLK(clk), .SYS_RST(rst), .i_DATA(din[0]), .i_WR(wr[0]), .o_FULL(full[0]),
    .o_EMPTY(empty[0]), .o_COUNT(cnt[0]), .o_OVERFLOW(ovf[0]), .o_BUSY(busy[0]), .o_TX(tx[0]));
  uart_tx_fifo #(.BAUD(10_000_000), .PARITY_EN(1), .PARITY_ODD(0)) u_pe (
    .SYS_CLK(clk), .SYS_RST(rst), .i_DATA(din[1]), .i_WR(wr[1]), .o_FULL(full[1]),
    .o_EMPTY(empty[1]), .o_COUNT(cnt[1]), .o_OVERFLOW(ovf[1]), .o_BUSY(busy[1]), .o_TX(tx[1]));
  uart_tx_fifo #(.BAUD(10_000_000), .PARITY_EN(1), .PARITY_ODD(1)) u_po (
    .SYS_CLK(clk), .SYS_RST(rst), .i_DATA(din[2]), .i_WR(wr[2]), .o_FULL(full[2]),
    .o_EMPTY(empty[2]), .o_COUNT(cnt[2]), .o_OVERFLOW(ovf[2]), .o_BUSY(busy[2]), .o_TX(tx[2]));
  uart_tx_fifo #(.BAUD(10_000_000), .STOP_BITS(2)) u_s2 (
    .SYS_CLK(clk), .SYS_RST(rst), .i_DATA(din[3]), .i_WR(wr[3]), .o_FULL(full[3]),
    .o_EMPTY(empty[3]), .o_COUNT(cnt[3]), .o_OVERFLOW(ovf[3]), .o_BUSY(busy[3]), .o_TX(tx[3]));

  // Expected line level k cycles into a frame at 10 clocks per bit.
  function automatic logic exp_lvl(input logic [7:0] b, input int k, input bit pen, input bit podd);
    int s;
    s = k / 10;
    if (s == 0) return 1'b0;
    if (s <= 8) return b[s-1];
    if (pen && s == 9) return podd ? ~^b : ^b;
    return 1'b1;
  endfunction

  task automatic test_reset;
    for (int i = 0; i < 4; i++) begin
      din[i] = 8'h00;
    end
    rst = 1'b1;
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      checks++;
      if ({tx[i], busy[i], empty[i], full[i], ovf[i]} !== 5'b10100 || cnt[i] !== 5'd0) begin
        failures++;
        $display("FAIL reset inst%0d: tx/busy/empty/full/ovf=%b count=%0d, want 10100 count=0",
                 i, {tx[i], busy[i], empty[i], full[i], ovf[i]}, cnt[i]);
      end
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_single_frame;
    int err = 0;
    din[0] = 8'h55; wr[0] = 1'b1;
    @(negedge clk);
    wr[0] = 1'b0;
    checks++;
    if (cnt[0] !== 5'd1 || tx[0] !== 1'b1) begin
      failures++;
      $display("FAIL single_after_write: count=%0d tx=%b, want 1 and 1", cnt[0], tx[0]);
    end
    for (int k = 0; k < 100; k++) begin
      @(negedge clk);
      if (tx[0] !== exp_lvl(8'h55, k, 0, 0) || busy[0] !== 1'b1) err++;
    end
    checks++;
    if (err != 0) begin
      failures++;
      $display("FAIL single_frame_0x55: %0d bad cycles, want 0", err);
    end
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || tx[0] !== 1'b1 || empty[0] !== 1'b1) begin
      failures++;
      $display("FAIL single_end: busy=%b tx=%b empty=%b, want 0 1 1", busy[0], tx[0], empty[0]);
    end
  endtask

  task automatic test_back_to_back;
    int err = 0;
    din[0] = 8'hA3; wr[0] = 1'b1;
    @(negedge clk);
    din[0] = 8'h0F;
    @(negedge clk);
    wr[0] = 1'b0;
    checks++;
    if (cnt[0] !== 5'd1) begin
      failures++;
      $display("FAIL b2b_count: count=%0d, want 1", cnt[0]);
    end
    for (int k = 0; k < 200; k++) begin
      if (k > 0) @(negedge clk);
      if (tx[0] !== exp_lvl(k < 100 ? 8'hA3 : 8'h0F, k % 100, 0, 0) || busy[0] !== 1'b1) err++;
      if (k == 100) begin
        checks++;
        if (empty[0] !== 1'b1) begin
          failures++;
          $display("FAIL b2b_empty_after_pop2: empty=%b, want 1", empty[0]);
        end
      end
    end
    checks++;
    if (err != 0) begin
      failures++;
      $display("FAIL b2b_frames: %0d bad cycles, want 0", err);
    end
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || tx[0] !== 1'b1) begin
      failures++;
      $display("FAIL b2b_end: busy=%b tx=%b, want 0 1", busy[0], tx[0]);
    end
  endtask

  task automatic test_overflow;
    int n = 0;
    for (int i = 0; i < 18; i++) begin
      din[0] = 8'(i + 1); wr[0] = 1'b1;
      @(negedge clk);
      if (i >= 1) begin samp[n] = tx[0]; n++; end
      if (i == 15) begin
        checks++;
        if (full[0] !== 1'b0 || cnt[0] !== 5'd15) begin
          failures++;
          $display("FAIL ovf_16th_write: full=%b count=%0d, want 0 15", full[0], cnt[0]);
        end
      end
      if (i == 16) begin
        checks++;
        if (full[0] !== 1'b1 || ovf[0] !== 1'b0) begin
          failures++;
          $display("FAIL ovf_17th_write: full=%b ovf=%b, want 1 0", full[0], ovf[0]);
        end
      end
    end
    wr[0] = 1'b0;
    checks++;
    if (ovf[0] !== 1'b1 || cnt[0] !== 5'd16) begin
      failures++;
      $display("FAIL ovf_18th_write: ovf=%b count=%0d, want 1 16", ovf[0], cnt[0]);
    end
    while (n < 1700) begin
      @(negedge clk);
      samp[n] = tx[0]; n++;
    end
    for (int f = 0; f < 17; f++) begin
      int err = 0;
      for (int k = 0; k < 100; k++)
        if (samp[f*100 + k] !== exp_lvl(8'(f + 1), k, 0, 0)) err++;
      checks++;
      if (err != 0) begin
        failures++;
        $display("FAIL ovf_frame%0d: %0d bad cycles, want 0", f, err);
      end
    end
    @(negedge clk);
    checks++;
    if (busy[0] !== 1'b0 || empty[0] !== 1'b1 || ovf[0] !== 1'b1) begin
      failures++;
      $display("FAIL ovf_end: busy=%b empty=%b ovf=%b, want 0 1 1", busy[0], empty[0], ovf[0]);
    end
  endtask

  task automatic test_parity;
    int err = 0;
    din[1] = 8'h07; din[2] = 8'h07; wr[1] = 1'b1; wr[2] = 1'b1;
    @(negedge clk);
    wr[1] = 1'b0; wr[2] = 1'b0;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (tx[1] !== exp_lvl(8'h07, k, 1, 0) || tx[2] !== exp_lvl(8'h07, k, 1, 1)) err++;
      if (busy[1] !== 1'b1 || busy[2] !== 1'b1) err++;
      if (k == 95) begin
        checks++;
        if (tx[1] !== 1'b1 || tx[2] !== 1'b0) begin
          failures++;
          $display("FAIL parity_bit: even=%b odd=%b, want 1 0", tx[1], tx[2]);
        end
      end
    end
    checks++;
    if (err != 0) begin
      failures++;
      $display("FAIL parity_frames: %0d bad cycles, want 0", err);
    end
    @(negedge clk);
    checks++;
    if (busy[1] !== 1'b0 || busy[2] !== 1'b0) begin
      failures++;
      $display("FAIL parity_len: busy even=%b odd=%b after 110 cycles, want 0 0", busy[1], busy[2]);
    end
  endtask

  task automatic test_stop2;
    int err = 0;
    din[3] = 8'h00; wr[3] = 1'b1;
    @(negedge clk);
    wr[3] = 1'b0;
    for (int k = 0; k < 110; k++) begin
      @(negedge clk);
      if (tx[3] !== (k >= 90) || busy[3] !== 1'b1) err++;
    end
    checks++;
    if (err != 0) begin
      failures++;
      $display("FAIL stop2_frame: %0d bad cycles, want 0", err);
    end
    @(negedge clk);
    checks++;
    if (busy[3] !== 1'b0 || tx[3] !== 1'b1) begin
      failures++;
      $display("FAIL stop2_len: busy=%b tx=%b, want 0 1", busy[3], tx[3]);
    end
  endtask

  task automatic test_reset_mid;
    int err = 0;
    din[0] = 8'h00; wr[0] = 1'b1;
    repeat (4) @(negedge clk);
    wr[0] = 1'b0;
    checks++;
    if (cnt[0] !== 5'd3) begin
      failures++;
      $display("FAIL rstmid_queued: count=%0d, want 3", cnt[0]);
    end
    repeat (27) @(negedge clk);
    checks++;
    if (tx[0] !== 1'b0 || busy[0] !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_pre: tx=%b busy=%b, want 0 1", tx[0], busy[0]);
    end
    #1 rst = 1'b1;
    #1;
    checks++;
    if (tx[0] !== 1'b1 || busy[0] !== 1'b0 || cnt[0] !== 5'd0 || empty[0] !== 1'b1) begin
      failures++;
      $display("FAIL rstmid_async: tx=%b busy=%b count=%0d empty=%b, want 1 0 0 1",
               tx[0], busy[0], cnt[0], empty[0]);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      if (tx[0] !== 1'b1 || busy[0] !== 1'b0) err++;
    end
    checks++;
    if (err != 0) begin
      failures++;
      $display("FAIL rstmid_no_frames: %0d active cycles after release, want 0", err);
    end
  endtask

  initial begin
    test_reset();
    test_single_frame();
    test_back_to_back();
    test_overflow();
    test_parity();
    test_stop2();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
